// File: rtl/uncached_store_handler_if.sv
// Store-side and single-beat AXI write bundle for the uncached store handler.
// master = handler view, slave = write buffer / interconnect view.
interface uncached_store_handler_if #(
  parameter int ID_WIDTH = 4
);
  logic                w;
  logic [31:0]         addr;
  logic [31:0]         data;
  logic [1:0]          size;
  logic                ready;
  logic                busy;
  logic                bus_err;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    input  w, addr, data, size,
    output ready, busy, bus_err,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output w, addr, data, size,
    input  ready, busy, bus_err,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncached_store_handler.sv
// Drains committed uncached stores one at a time as single-beat AXI writes,
// pulsing ready for one cycle after each B response. One transaction in flight.
module uncached_store_handler #(
  parameter int ID_WIDTH = 4,
  parameter int WR_ID    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  uncached_store_handler_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } req_t;

  state_t          state, state_nx;
  req_t            req_q;
  logic            aw_done, w_done, bus_err_q;
  logic            aw_hs, w_hs, b_hs;
  logic [3:0]      strb_lane;
  logic [3:0][7:0] data_lane;

  // Per byte lane: strobe and replicated data. size=11 falls into the word case.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    always_comb begin
      strb_lane[i] = 1'b1;
      data_lane[i] = bus.data[8*i +: 8];
      unique case (bus.size)
        2'b00: begin
          strb_lane[i] = (bus.addr[1:0] == LANE);
          data_lane[i] = bus.data[7:0];
        end
        2'b01: begin
          strb_lane[i] = (bus.addr[1] == LANE[1]);
          data_lane[i] = bus.data[8*LANE[0] +: 8];
        end
        default: ;
      endcase
    end
  end

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid  & bus.wready;
  assign b_hs  = bus.bvalid  & bus.bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.w) state_nx = SEND;
      SEND:    if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = WAIT_B;
      WAIT_B:  if (bus.bvalid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request is latched only in IDLE so AW/W payload is stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.w)
        req_q <= '{addr: bus.addr, wdata: data_lane, wstrb: strb_lane, size: bus.size};
      aw_done <= (state == SEND) ? (aw_done | aw_hs) : 1'b0;
      w_done  <= (state == SEND) ? (w_done  | w_hs)  : 1'b0;
      if (b_hs && bus.bresp != 2'b00) bus_err_q <= 1'b1;
    end
  end

  // Channel valids derive from flops only, so they drop the cycle after their own handshake.
  assign bus.awvalid = (state == SEND) & ~aw_done;
  assign bus.wvalid  = (state == SEND) & ~w_done;
  assign bus.bready  = (state == WAIT_B);
  assign bus.ready   = (state == DONE);
  assign bus.busy    = (state != IDLE);
  assign bus.bus_err = bus_err_q;

  assign bus.awid    = ID_WIDTH'(WR_ID);
  assign bus.awaddr  = req_q.addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, req_q.size};
  assign bus.awburst = 2'b01;
  assign bus.wdata   = req_q.wdata;
  assign bus.wstrb   = req_q.wstrb;
  assign bus.wlast   = 1'b1;

endmodule

// File: tb/tb_uncached_store_handler.sv
// Scoreboard bench: write-buffer driver and AXI slave push/compare against a
// lane-arithmetic model of each store's expected AW/W payload.
module tb_uncached_store_handler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uncached_store_handler_if #(.ID_WIDTH(4)) bus ();
  uncached_store_handler #(.ID_WIDTH(4), .WR_ID(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [1:0] size;} st_t;
  typedef struct packed {logic [31:0] awaddr; logic [2:0] awsize; logic [31:0] wdata; logic [3:0] wstrb;} exp_t;

  localparam int M_FAST = 0, M_AWHOLD = 1, M_RAND = 2, M_BSTALL = 3, M_ERR = 4;

  st_t  wb_q[$];
  exp_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0, mode = M_FAST;
  int   aw_cnt, ready_cnt, b_cnt, pending_b, b_wait, aw_stall, w_cyc;
  bit   aw_got, w_got, lat_chk, prev_ready, prev_awv, prev_awr, prev_wv, prev_wr;
  logic exp_bus_err;
  logic [31:0] prev_awaddr, prev_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected payload from plain lane arithmetic.
  function automatic exp_t model(input st_t s);
    exp_t e;
    int   lane;
    e.awaddr = s.addr;
    e.awsize = {1'b0, s.size};
    case (s.size)
      2'd0: begin
        lane    = int'(s.addr % 4);
        e.wstrb = 4'(1 << lane);
        e.wdata = {24'd0, s.data[7:0]} * 32'h0101_0101;
      end
      2'd1: begin
        lane    = int'((s.addr / 2) % 2) * 2;
        e.wstrb = 4'(3 << lane);
        e.wdata = {16'd0, s.data[15:0]} * 32'h0001_0001;
      end
      default: begin
        e.wstrb = 4'hF;
        e.wdata = s.data;
      end
    endcase
    return e;
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_t s;
    s = '{addr: a, data: d, size: sz};
    wb_q.push_back(s);
    exp_q.push_back(model(s));
  endtask

  task automatic clear_sb();
    wb_q.delete(); exp_q.delete();
    aw_cnt = 0; ready_cnt = 0; b_cnt = 0; pending_b = 0; b_wait = 0; aw_stall = 0;
    aw_got = 0; w_got = 0; lat_chk = 0; exp_bus_err = 1'b0;
    prev_ready = 0; prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
    prev_awaddr = '0; prev_wdata = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wb_q.size() > 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain within budget", 64'(n < 3000), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Write buffer + AXI slave + monitor, all evaluated at the falling edge.
  initial begin
    bit aw_fire, w_fire, b_fire;
    bus.w = 0; bus.addr = '0; bus.data = '0; bus.size = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.w = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
      end else begin
        if (bus.ready) begin
          check("ready follows B", 64'(b_cnt), 64'(ready_cnt + 1));
          check("bus_err at ready", 64'(bus.bus_err), 64'(exp_bus_err));
          check("ready single cycle", 64'(prev_ready), 64'd0);
          if (lat_chk) begin
            check("w to ready cycles", 64'(cyc - w_cyc + 1), 64'd4);
            lat_chk = 0;
          end
          ready_cnt++;
          if (wb_q.size() > 0) void'(wb_q.pop_front());
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          aw_got = 0; w_got = 0;
        end
        prev_ready = bus.ready;

        // Head of write buffer; handler ignores w during DONE so the next entry can appear now.
        if (wb_q.size() > 0 && !bus.w) w_cyc = cyc;
        bus.w = (wb_q.size() > 0);
        if (wb_q.size() > 0) begin
          bus.addr = wb_q[0].addr; bus.data = wb_q[0].data; bus.size = wb_q[0].size;
        end

        if (pending_b > 0) begin
          if (b_wait > 0) begin
            b_wait--;
            bus.bvalid = 0;
          end else begin
            if (!bus.bvalid)
              bus.bresp = (mode == M_ERR) ? 2'b10 :
                          (mode == M_RAND && $urandom_range(7) == 0) ? 2'b10 : 2'b00;
            bus.bvalid = 1;
          end
        end else bus.bvalid = 0;

        case (mode)
          M_AWHOLD: begin
            bus.wready  = 1;
            bus.awready = bus.awvalid && aw_stall >= 5;
            if (bus.awvalid && !bus.awready) aw_stall++;
          end
          M_RAND: begin
            bus.awready = ($urandom_range(2) == 0);
            bus.wready  = ($urandom_range(2) == 0);
          end
          default: begin
            bus.awready = 1;
            bus.wready  = 1;
          end
        endcase

        aw_fire = bus.awvalid && bus.awready;
        w_fire  = bus.wvalid && bus.wready;
        b_fire  = bus.bvalid && bus.bready;

        if (bus.awvalid && prev_awv && !prev_awr) check("awaddr stable", bus.awaddr, prev_awaddr);
        if (bus.wvalid && prev_wv && !prev_wr)    check("wdata stable", bus.wdata, prev_wdata);
        if (bus.awvalid && !prev_awv) check("aw after prior ready", 64'(aw_cnt), 64'(ready_cnt));
        if (bus.wvalid && !prev_wv)   check("w after prior ready", 64'(w_got), 64'd0);

        if (aw_fire) begin
          if (exp_q.size() == 0) check("unexpected AW", 64'd1, 64'd0);
          else begin
            check("awaddr", bus.awaddr, exp_q[0].awaddr);
            check("awsize", 64'(bus.awsize), 64'(exp_q[0].awsize));
            check("awid", 64'(bus.awid), 64'd1);
            check("awlen/awburst", {bus.awlen, bus.awburst}, {8'd0, 2'b01});
          end
          check("single AW beat", 64'(aw_got), 64'd0);
          if (mode == M_AWHOLD) check("awvalid stall cycles", 64'(aw_stall), 64'd5);
          aw_stall = 0;
          aw_got = 1;
          aw_cnt++;
        end
        if (w_fire) begin
          if (exp_q.size() == 0) check("unexpected W", 64'd1, 64'd0);
          else begin
            check("wdata", bus.wdata, exp_q[0].wdata);
            check("wstrb", 64'(bus.wstrb), 64'(exp_q[0].wstrb));
            check("wlast", 64'(bus.wlast), 64'd1);
          end
          check("single W beat", 64'(w_got), 64'd0);
          w_got = 1;
        end
        if ((aw_fire || w_fire) && aw_got && w_got) begin
          pending_b++;
          b_wait = (mode == M_BSTALL) ? (1 << 30) : (mode == M_RAND) ? int'($urandom_range(3)) : 0;
        end
        if (b_fire) begin
          b_cnt++;
          pending_b--;
          if (bus.bresp != 2'b00) exp_bus_err = 1'b1;
        end

        prev_awv = bus.awvalid; prev_awr = bus.awready; prev_awaddr = bus.awaddr;
        prev_wv  = bus.wvalid;  prev_wr  = bus.wready;  prev_wdata  = bus.wdata;
      end
    end
  end

  initial begin
    int n;
    rst = 1;
    clear_sb();
    repeat (3) @(negedge clk);
    check("rst awvalid/wvalid/bready", {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
    check("rst ready/busy/bus_err", {bus.ready, bus.busy, bus.bus_err}, 3'b000);
    check("rst latched regs", {bus.awaddr, bus.wdata, bus.wstrb}, 68'd0);
    @(negedge clk);
    rst = 0;

    // Word store, all ready, minimum latency.
    mode = M_FAST;
    @(posedge clk); #2;
    push(32'hBFD0_0010, 32'h1234_5678, 2'd2);
    lat_chk = 1;
    wait_idle();

    // Byte then half back-to-back with w held.
    @(posedge clk); #2;
    push(32'h1000_0003, 32'h0000_00AB, 2'd0);
    push(32'h1000_0002, 32'h0000_BEEF, 2'd1);
    wait_idle();

    // W accepted at once, AW stalled 5 cycles.
    mode = M_AWHOLD;
    @(posedge clk); #2;
    push(32'h2000_0008, 32'hCAFE_F00D, 2'd2);
    wait_idle();

    // Error response, then an OKAY one: bus_err must stick.
    mode = M_ERR;
    @(posedge clk); #2;
    push(32'h3000_0001, 32'h0000_0055, 2'd0);
    wait_idle();
    mode = M_FAST;
    @(posedge clk); #2;
    push(32'h3000_0004, 32'h0000_1122, 2'd1);
    wait_idle();
    check("bus_err sticky", 64'(bus.bus_err), 64'd1);

    // Random stores, random channel readiness, occasional errors.
    mode = M_RAND;
    @(posedge clk); #2;
    for (int i = 0; i < 40; i++)
      push($urandom, $urandom, 2'($urandom_range(3)));
    wait_idle();

    // Reset while waiting on B.
    mode = M_BSTALL;
    @(posedge clk); #2;
    push(32'h4000_0000, 32'hDEAD_BEEF, 2'd2);
    n = 0;
    while (!bus.bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached WAIT_B", 64'(bus.bready), 64'd1);
    #2 rst = 1;
    #1;
    check("async rst valids/bready", {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
    check("async rst ready/busy/bus_err", {bus.ready, bus.busy, bus.bus_err}, 3'b000);
    clear_sb();
    repeat (2) @(negedge clk);
    rst = 0;

    // Recovery after reset.
    mode = M_FAST;
    @(posedge clk); #2;
    push(32'h5000_0002, 32'h0000_7788, 2'd1);
    lat_chk = 1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
